seg7_mux_driver: RTL and testbench
==================================

Name: seg7_mux_driver

Overview:
- Downstream display stage for the up/down counter; consumes its 7-bit binary count (0..99 nominal).
- Converts the count to two BCD digits with a sequential double-dabble FSM.
- Drives a 2-digit common-anode multiplexed seven-segment display with a refresh divider and an inter-digit blanking gap.
- seg_out and anode map directly to board pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 500: cycles at slot start with both anodes off (anti-ghosting).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  7  binary count from the counter stage.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- anode  out  2  digit enables, active-low; [0]=ones, [1]=tens.
- digit_tens  out  4  latched tens BCD (4'hF = overflow).
- digit_ones  out  4  latched ones BCD (4'hF = overflow).
- conv_busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (async, immediate):
  - seg_out=7'h7F, anode=2'b11, digit_tens=digit_ones=0, conv_busy=0.
  - last_value=0, refresh counter=0, digit_sel=0 (ones), FSM=IDLE.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if value != last_value, capture value into the shift register, set last_value=value, ovf=(value>99), step=0, go to SHIFT (capture edge = E0).
  - SHIFT: each edge, add 3 to every BCD nibble >=5, then shift left one bit. Runs 7 edges (E1..E7); E7 moves to DONE.
  - DONE (E8): load digit_tens/digit_ones, or 4'hF/4'hF if ovf; return to IDLE.
  - conv_busy is registered high from E0 through E8 (states SHIFT and DONE).
  - Digit-to-display latency: digits update at E8. seg_out reflects them on the next edge while that digit is active.
  - value changes while busy are ignored until IDLE, then re-compared with last_value. The display always converges to the last stable value.
- Refresh mux:
  - Counter runs 0..REFRESH_DIV-1 free. digit_sel toggles at wrap.
  - Counter < BLANK_CYCLES: anode=2'b11, seg_out=7'h7F.
  - Otherwise the selected anode bit=0, the other=1, and seg_out=decode(selected digit).
  - seg_out and anode are registered: one cycle behind the counter state.
- Decode, active-low:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 4'hF = dash 7'h3F. 4'hA..4'hE = blank 7'h7F.
- Boundaries:
  - value=99 gives 9/9.
  - value 100..127 gives dash/dash.
  - value 0 after reset triggers no conversion; the display shows 0/0.
  - Reset mid-conversion aborts the FSM and restores reset values.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when digit_tens==0 and not overflow, anode[1] stays 1 and seg_out=7'h7F during the tens slot. value=5 shows " 5".
- Undefined: the tens digit always displays; value=5 shows "05".

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset asserted mid-run -> anode=2'b11, seg_out=7'h7F, conv_busy=0, digits 0/0 immediately, without waiting for a clock edge.
- value 0->42 -> conv_busy high for exactly 9 cycles; digit_tens=4, digit_ones=2 at E8; tens slot seg_out=7'h19, ones slot seg_out=7'h24.
- value=120 -> digits 4'hF/4'hF; both slots seg_out=7'h3F. value=99 -> 9/9, seg_out=7'h10 both slots.
- value 42, then 57 at E3 of that conversion -> first conversion completes (4/2), a second conversion starts the next IDLE cycle, final digits 5/7.
- Steady value -> anode repeats 11,11,10,10,10,10,10,10 then 11,11,01,01,01,01,01,01 (per-cycle, one-cycle register lag).
- value=5: with LEADING_ZERO_BLANK_EN, tens slot anode stays 2'b11; without it, tens slot anode=2'b01 with seg_out=7'h40.

Source files
------------

// File: rtl/seg7_mux_driver_if.sv
// Display-side bundle for seg7_mux_driver: binary count in, BCD digits, pin drives and busy flag out.
// The master is the counter/board side; the slave is the display driver.
interface seg7_mux_driver_if;
   logic [6:0] value;
   logic [6:0] seg_out;
   logic [1:0] anode;
   logic [3:0] digit_tens;
   logic [3:0] digit_ones;
   logic       conv_busy;

   modport master (
      output value,
      input  seg_out,
      input  anode,
      input  digit_tens,
      input  digit_ones,
      input  conv_busy
   );

   modport slave (
      input  value,
      output seg_out,
      output anode,
      output digit_tens,
      output digit_ones,
      output conv_busy
   );
endinterface

// File: rtl/seg7_mux_driver.sv
// Binary-to-BCD (sequential double dabble) plus 2-digit multiplexed common-anode 7-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit instead of showing "0".
module seg7_mux_driver #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_mux_driver_if.slave  bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [14:0]      sr_q, sr_d;
   logic [2:0]       step_q, step_d;
   logic [6:0]       last_q, last_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       anode_q, anode_d;
   logic [3:0]       disp_s;

   // Shift register layout is {tens[14:11], ones[10:7], binary[6:0]}.
   function automatic logic [14:0] dd_step(input logic [14:0] s);
      logic [3:0] t;
      logic [3:0] o;
      t = (s[14:11] >= 4'd5) ? (s[14:11] + 4'd3) : s[14:11];
      o = (s[10:7]  >= 4'd5) ? (s[10:7]  + 4'd3) : s[10:7];
      return {t[2:0], o, s[6:0], 1'b0};
   endfunction

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] r;
      case (d)
         4'h0:    r = 7'h40;
         4'h1:    r = 7'h79;
         4'h2:    r = 7'h24;
         4'h3:    r = 7'h30;
         4'h4:    r = 7'h19;
         4'h5:    r = 7'h12;
         4'h6:    r = 7'h02;
         4'h7:    r = 7'h78;
         4'h8:    r = 7'h00;
         4'h9:    r = 7'h10;
         4'hF:    r = 7'h3F;
         default: r = 7'h7F;
      endcase
      return r;
   endfunction

   // Converter FSM: capture on change, seven add-3/shift steps, then latch digits.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      step_d  = step_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.value != last_q) begin
               sr_d    = {8'd0, bus.value};
               last_d  = bus.value;
               ovf_d   = (bus.value > 7'd99);
               step_d  = 3'd0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               busy_d  = 1'b0;
            end
         end
         ST_SHIFT: begin
            sr_d   = dd_step(sr_q);
            busy_d = 1'b1;
            if (step_q == 3'd6) begin
               step_d  = 3'd0;
               state_d = ST_DONE;
            end else begin
               step_d  = step_q + 3'd1;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b1;
            state_d = ST_IDLE;
            if (ovf_q) begin
               tens_d = 4'hF;
               ones_d = 4'hF;
            end else begin
               tens_d = sr_q[14:11];
               ones_d = sr_q[10:7];
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Refresh divider, digit select and the registered pin drive values.
   always_comb begin
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      sel_d   = sel_q;
      anode_d = 2'b11;
      seg_d   = 7'h7F;
      disp_s  = sel_q ? tens_q : ones_q;
      if (cnt_q == DIV_LAST) begin
         cnt_d = {CNT_W{1'b0}};
         sel_d = ~sel_q;
      end else begin
         sel_d = sel_q;
      end
      if (cnt_q < BLANK_C) begin
         anode_d = 2'b11;
         seg_d   = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
      end else if (sel_q && (tens_q == 4'h0)) begin
         anode_d = 2'b11;
         seg_d   = 7'h7F;
`endif
      end else begin
         anode_d = sel_q ? 2'b01 : 2'b10;
         seg_d   = decode(disp_s);
      end
   end

   // State and output registers; reset blanks the display immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= 15'd0;
         step_q  <= 3'd0;
         last_q  <= 7'd0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         cnt_q   <= {CNT_W{1'b0}};
         sel_q   <= 1'b0;
         seg_q   <= 7'h7F;
         anode_q <= 2'b11;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         step_q  <= step_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
         anode_q <= anode_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.anode      = anode_q;
   assign bus.digit_tens = tens_q;
   assign bus.digit_ones = ones_q;
   assign bus.conv_busy  = busy_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Randomized self-checking bench for seg7_mux_driver against a per-cycle behavioural model.
// Build with or without LEADING_ZERO_BLANK_EN; the model follows the same macro.
module tb_seg7_mux_driver;

   localparam int DIV = 8;
   localparam int BLK = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   seg7_mux_driver_if bus ();

   seg7_mux_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         4'hF: return 7'h3F;
         default: return 7'h7F;
      endcase
   endfunction

   // Model: display slot from elapsed cycles, digits appear 8 edges after a start, busy lasts 9.
   logic [6:0] v_seen;
   always @(posedge clk) v_seen <= bus.value;

   int         m_cnt, m_sel, m_timer;
   logic [6:0] m_last;
   logic [3:0] m_tens, m_ones, m_pt, m_po;
   logic [1:0] e_anode;
   logic [6:0] e_seg;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_cnt = 0; m_sel = 0; m_timer = 0; m_last = 7'd0;
         m_tens = 4'd0; m_ones = 4'd0;
         e_anode = 2'b11; e_seg = 7'h7F;
      end else begin
         if (m_cnt < BLK) begin
            e_anode = 2'b11; e_seg = 7'h7F;
         end else if (m_sel == 0) begin
            e_anode = 2'b10; e_seg = seg_of(m_ones);
`ifdef LEADING_ZERO_BLANK_EN
         end else if (m_tens == 4'd0) begin
            e_anode = 2'b11; e_seg = 7'h7F;
`endif
         end else begin
            e_anode = 2'b01; e_seg = seg_of(m_tens);
         end
         m_cnt = (m_cnt + 1) % DIV;
         if (m_cnt == 0) m_sel = 1 - m_sel;
         if (m_timer <= 1) begin
            m_timer = 0;
            if (v_seen != m_last) begin
               m_last  = v_seen;
               m_timer = 9;
               if (v_seen > 7'd99) begin
                  m_pt = 4'hF; m_po = 4'hF;
               end else begin
                  m_pt = 4'(int'(v_seen) / 10); m_po = 4'(int'(v_seen) % 10);
               end
            end
         end else begin
            m_timer = m_timer - 1;
            if (m_timer == 1) begin
               m_tens = m_pt; m_ones = m_po;
            end
         end
      end
      chk("model_anode", bus.anode, e_anode);
      chk("model_seg", bus.seg_out, e_seg);
      chk("model_busy", bus.conv_busy, (m_timer != 0) ? 1 : 0);
      chk("model_tens", bus.digit_tens, m_tens);
      chk("model_ones", bus.digit_ones, m_ones);
   end

   task automatic wait_busy_low();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.conv_busy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("busy_low_timeout", ok, 1);
   endtask

   task automatic wait_anode(input logic [1:0] a);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.anode == a) begin ok = 1'b1; break; end
      end
      chk("anode_wait_timeout", ok, 1);
   endtask

   task automatic convert(input logic [6:0] v);
      @(posedge clk); #1 bus.value = v;
      repeat (2) @(negedge clk);
      wait_busy_low();
   endtask

   logic [1:0] pat [16];
   int busy_cnt, hit;

   initial begin
      pat = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
              2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      bus.value = 7'd0;
      repeat (3) @(negedge clk);
      chk("rst_anode", bus.anode, 2'b11);
      chk("rst_seg", bus.seg_out, 7'h7F);
      #1 rst_n = 1'b1;

      // Value 0 after reset: no conversion, fixed slot pattern.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("anode_seq", bus.anode, pat[i]);
         chk("idle_busy", bus.conv_busy, 0);
      end

      // 0 -> 42: busy width and pinned digit/segment values.
      @(posedge clk); #1 bus.value = 7'd42;
      busy_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (bus.conv_busy) busy_cnt++;
      end
      chk("busy_width", busy_cnt, 9);
      chk("t42", bus.digit_tens, 4);
      chk("o42", bus.digit_ones, 2);
      wait_anode(2'b01); chk("seg_t42", bus.seg_out, 7'h19);
      wait_anode(2'b10); chk("seg_o42", bus.seg_out, 7'h24);

      convert(7'd120);
      chk("t120", bus.digit_tens, 4'hF);
      chk("o120", bus.digit_ones, 4'hF);
      wait_anode(2'b01); chk("seg_t120", bus.seg_out, 7'h3F);
      wait_anode(2'b10); chk("seg_o120", bus.seg_out, 7'h3F);

      convert(7'd99);
      chk("t99", bus.digit_tens, 9);
      chk("o99", bus.digit_ones, 9);
      wait_anode(2'b01); chk("seg_t99", bus.seg_out, 7'h10);
      wait_anode(2'b10); chk("seg_o99", bus.seg_out, 7'h10);

      // 42, then 57 while converting: 4/2 at E8, restart, final 5/7.
      @(posedge clk); #1 bus.value = 7'd42;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 bus.value = 7'd57;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t42_e8", bus.digit_tens, 4);
      chk("o42_e8", bus.digit_ones, 2);
      @(negedge clk);
      chk("restart_busy", bus.conv_busy, 1);
      wait_busy_low();
      chk("t57", bus.digit_tens, 5);
      chk("o57", bus.digit_ones, 7);

      convert(7'd5);
`ifdef LEADING_ZERO_BLANK_EN
      hit = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.anode == 2'b01) hit++;
      end
      chk("lzb_tens_off", hit, 0);
`else
      wait_anode(2'b01); chk("seg_t05", bus.seg_out, 7'h40);
`endif

      // Random values with random hold times, checked by the model every cycle.
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1 bus.value = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(100, 127))
                                                    : 7'($urandom_range(0, 99));
         repeat ($urandom_range(1, 24)) @(posedge clk);
      end

      // Asynchronous reset in the middle of a conversion.
      @(posedge clk); #1 bus.value = 7'd33;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_anode", bus.anode, 2'b11);
      chk("arst_seg", bus.seg_out, 7'h7F);
      chk("arst_busy", bus.conv_busy, 0);
      chk("arst_tens", bus.digit_tens, 0);
      chk("arst_ones", bus.digit_ones, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      wait_busy_low();
      chk("t33", bus.digit_tens, 3);
      chk("o33", bus.digit_ones, 3);

      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1 bus.value = 7'($urandom_range(0, 127));
         repeat ($urandom_range(1, 20)) @(posedge clk);
      end
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
